// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: expands one register read/write request into an I2C master command stream.
// Optional per-command watchdog enabled by defining I2C_SEQ_TIMEOUT_EN (limit TIMEOUT_CYCLES).
`default_nettype none

module i2c_txn_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_nack,
  output logic [2:0] o_cmd,
  output logic       o_wr_i2c,
  output logic [7:0] o_din,
  input  logic       i_ready,
  input  logic [7:0] i_dout,
  input  logic       i_ack
);

  localparam logic [2:0] CMD_START   = 3'b001;
  localparam logic [2:0] CMD_WR      = 3'b010;
  localparam logic [2:0] CMD_RD      = 3'b011;
  localparam logic [2:0] CMD_STOP    = 3'b100;
  localparam logic [2:0] CMD_RESTART = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG, S_DATA, S_RESTART,
    S_DEV_R, S_READ, S_STOP, S_WAIT, S_DONE
  } state_t;

  state_t     state_q, state_d, state_nx, phase_q, phase_d;
  logic       first_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q;
  logic       accept, issue, cap, set_nack, nack_hit;
  logic [2:0] cmd_d;
  logic [7:0] din_d;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    accept   = 1'b0;
    issue    = 1'b0;
    cap      = 1'b0;
    set_nack = 1'b0;
    cmd_d    = o_cmd;
    din_d    = o_din;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = S_START;
        end
      end
      S_WAIT: begin
        // The controller's ready may still be high in the cycle right after the strobe.
        if (!first_q && i_ready) begin
          case (phase_q)
            S_START:   state_d = S_DEV_W;
            S_DEV_W:   state_d = i_ack ? S_STOP : S_REG;
            S_REG:     state_d = i_ack ? S_STOP : (rw_q ? S_RESTART : S_DATA);
            S_DATA:    state_d = S_STOP;
            S_RESTART: state_d = S_DEV_R;
            S_DEV_R:   state_d = i_ack ? S_STOP : S_READ;
            S_READ: begin
              cap     = 1'b1;
              state_d = S_STOP;
            end
            default:   state_d = S_DONE;
          endcase
          set_nack = i_ack && (phase_q == S_DEV_W || phase_q == S_REG ||
                               phase_q == S_DATA  || phase_q == S_DEV_R);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (i_ready) begin
          issue   = 1'b1;
          phase_d = state_q;
          state_d = S_WAIT;
          din_d   = 8'h00;
          case (state_q)
            S_START:   cmd_d = CMD_START;
            S_DEV_W: begin cmd_d = CMD_WR; din_d = {dev_q, 1'b0}; end
            S_REG:   begin cmd_d = CMD_WR; din_d = reg_q; end
            S_DATA:  begin cmd_d = CMD_WR; din_d = wdata_q; end
            S_RESTART: cmd_d = CMD_RESTART;
            S_DEV_R: begin cmd_d = CMD_WR; din_d = {dev_q, 1'b1}; end
            S_READ:  begin cmd_d = CMD_RD; din_d = 8'h01; end
            default:   cmd_d = CMD_STOP;
          endcase
        end
      end
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt;
  logic          waiting, tmo_hit;

  assign waiting  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tmo_hit  = waiting && (state_d == state_q) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign state_nx = tmo_hit ? S_DONE : state_d;
  assign nack_hit = set_nack || tmo_hit;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                           tmo_cnt <= '0;
    else if (!waiting || state_nx != state_q) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign state_nx = state_d;
  assign nack_hit = set_nack;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      phase_q <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      phase_q <= phase_d;
      first_q <= issue;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rw_q     <= 1'b0;
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      wdata_q  <= 8'd0;
      o_nack   <= 1'b0;
      o_rdata  <= 8'd0;
      o_cmd    <= 3'b000;
      o_din    <= 8'd0;
      o_wr_i2c <= 1'b0;
    end else begin
      if (accept) begin
        rw_q    <= i_rw;
        dev_q   <= i_dev_addr;
        reg_q   <= i_reg_addr;
        wdata_q <= i_wdata;
      end
      if (accept)        o_nack <= 1'b0;
      else if (nack_hit) o_nack <= 1'b1;
      if (cap) o_rdata <= i_dout;
      o_cmd    <= cmd_d;
      o_din    <= din_d;
      o_wr_i2c <= issue;
    end
  end

  assign o_busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done = (state_q == S_DONE);

endmodule

`default_nettype wire
